// File: rtl/dice_pkg.sv
// dice_pkg: shared definitions for the dice-roll controller.
//   - die codes (0..5, same order as the button bits)
//   - controller FSM state encoding
//   - default parameter values
//   - lowest_set(): priority pick of the lowest-index set bit
package dice_pkg;

  localparam int NUM_BTN = 6;

  localparam int DEF_DEBOUNCE_CYCLES = 328;    // ~10 ms at 32768 Hz
  localparam int DEF_SETTLE_STEPS    = 8;
  localparam int DEF_SHOW_CYCLES     = 65536;  // 2 s at 32768 Hz

  typedef logic [2:0] die_code_t;

  localparam die_code_t DIE_D4   = 3'd0;
  localparam die_code_t DIE_D6   = 3'd1;
  localparam die_code_t DIE_D8   = 3'd2;
  localparam die_code_t DIE_D10  = 3'd3;
  localparam die_code_t DIE_D20  = 3'd4;
  localparam die_code_t DIE_D100 = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROLLING,
    ST_SETTLING,
    ST_SHOW
  } state_t;

  // Lowest-index set bit wins (D4 has the highest priority).
  function automatic die_code_t lowest_set(input logic [NUM_BTN-1:0] v);
    die_code_t code;
    code = DIE_D4;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (v[i]) code = die_code_t'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/dice_roll_ctrl_if.sv
// dice_roll_ctrl_if: button/enable inputs and counter-control outputs of the
// dice-roll controller.
//   btn     : raw die-select buttons (bit 0 = D4 ... bit 5 = D100)
//   ena     : design enable
//   die_sel : granted die code, stable for the whole roll
//   load    : one-cycle strobe, counter loads the die maximum
//   tick    : one-cycle decrement strobe
//   busy    : roll in progress (rolling or settling)
//   show    : result display enable
// master drives the buttons/enable, slave is the controller.
interface dice_roll_ctrl_if;
  import dice_pkg::*;

  logic [NUM_BTN-1:0] btn;
  logic               ena;
  die_code_t          die_sel;
  logic               load;
  logic               tick;
  logic               busy;
  logic               show;

  modport master (
    output btn, ena,
    input  die_sel, load, tick, busy, show
  );

  modport slave (
    input  btn, ena,
    output die_sel, load, tick, busy, show
  );

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: one button input conditioner.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : asynchronous raw button level
//   level      : debounced level, follows the synchronized input only after
//                it has held a new value for DEBOUNCE_CYCLES consecutive cycles
//   rise       : one-cycle pulse, registered together with a 0->1 level change
module btn_debounce
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;  // [0] first stage, [1] synchronized level
  logic [CW-1:0] cnt_q;   // cycles the synced input has differed from level

  // NOTE: every flop, counters included, is cleared by the asynchronous
  // reset so a mid-roll reset leaves no stale debounce history behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the two synchronizer stages
      // shift by one flop per edge instead of collapsing into a wire.
      sync_q <= {sync_q[0], raw};
      rise   <= 1'b0;
      if (sync_q[1] == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // This edge is the DEBOUNCE_CYCLES-th consecutive differing sample.
        level <= sync_q[1];
        rise  <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/dice_roll_ctrl.sv
// dice_roll_ctrl: sequences the two-digit BCD down-counter through a roll.
//   clk, rst_n : 32768 Hz clock, asynchronous active-low reset
//   bus        : slave side of dice_roll_ctrl_if
//                (btn/ena in; die_sel/load/tick/busy/show out, all registered)
// Six debounced buttons feed a priority arbiter; the FSM loads the granted
// die maximum, ticks every cycle while the button is held, then ticks with
// doubling intervals (2, 4, ... 2^SETTLE_STEPS) and finally shows the result
// for SHOW_CYCLES cycles. A press while showing starts a new roll at once.
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SETTLE_STEPS    = DEF_SETTLE_STEPS,
  parameter int SHOW_CYCLES     = DEF_SHOW_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  dice_roll_ctrl_if.slave bus
);

  localparam int ICW = SETTLE_STEPS + 1;            // interval counter
  localparam int SCW = $clog2(SETTLE_STEPS + 1);    // settle step counter
  localparam int WCW = $clog2(SHOW_CYCLES + 1);     // show counter

  localparam logic [SCW-1:0] STEP_LAST = SCW'(SETTLE_STEPS);
  localparam logic [WCW-1:0] SHOW_LAST = WCW'(SHOW_CYCLES - 1);

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] rise;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (bus.btn[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  state_t         state_q, state_n;
  die_code_t      die_q, die_n;
  logic           load_q, load_n;
  logic           tick_q, tick_n;
  logic           busy_q, show_q;
  logic [ICW-1:0] ivl_q, ivl_n, ivl_inc, ivl_target;
  logic [SCW-1:0] step_q, step_n;
  logic [WCW-1:0] show_cnt_q, show_cnt_n;
  logic           granted_held;

  assign granted_held = |(level & (NUM_BTN'(1) << die_q));
  assign ivl_inc      = ivl_q + ICW'(1);
  // Interval before settle tick k+1 is 2^(k+1) cycles, k = ticks done so far.
  assign ivl_target   = ICW'(2) << step_q;

  // NOTE: every variable gets its default at the top of the block, so no
  // path through the case statement can leave one unassigned (no latches).
  always_comb begin
    state_n    = state_q;
    die_n      = die_q;
    load_n     = 1'b0;
    tick_n     = 1'b0;
    ivl_n      = ivl_q;
    step_n     = step_q;
    show_cnt_n = show_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|rise) begin
          state_n = ST_ROLLING;
          die_n   = lowest_set(rise);
          load_n  = 1'b1;
        end
      end

      ST_ROLLING: begin
        // The edge that leaves ROLLING still issues a tick; that tick is
        // the entry cycle from which the first settle interval counts.
        tick_n = 1'b1;
        if (!granted_held) begin
          state_n = ST_SETTLING;
          ivl_n   = '0;
          step_n  = '0;
        end
      end

      ST_SETTLING: begin
        if (step_q == STEP_LAST) begin
          state_n    = ST_SHOW;
          ivl_n      = '0;
          step_n     = '0;
          show_cnt_n = '0;
        end else if (ivl_inc == ivl_target) begin
          tick_n = 1'b1;
          ivl_n  = '0;
          step_n = step_q + SCW'(1);
        end else begin
          ivl_n = ivl_inc;
        end
      end

      ST_SHOW: begin
        if (|rise) begin
          state_n    = ST_ROLLING;
          die_n      = lowest_set(rise);
          load_n     = 1'b1;
          show_cnt_n = '0;
        end else if (show_cnt_q == SHOW_LAST) begin
          state_n    = ST_IDLE;
          show_cnt_n = '0;
        end else begin
          show_cnt_n = show_cnt_q + WCW'(1);
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // Disable wins over everything; debouncers keep running regardless.
    if (!bus.ena) begin
      state_n    = ST_IDLE;
      load_n     = 1'b0;
      tick_n     = 1'b0;
      ivl_n      = '0;
      step_n     = '0;
      show_cnt_n = '0;
    end

    if (state_n == ST_IDLE) die_n = DIE_D4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      die_q      <= DIE_D4;
      load_q     <= 1'b0;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
      show_q     <= 1'b0;
      ivl_q      <= '0;
      step_q     <= '0;
      show_cnt_q <= '0;
    end else begin
      state_q    <= state_n;
      die_q      <= die_n;
      load_q     <= load_n;
      tick_q     <= tick_n;
      busy_q     <= (state_n == ST_ROLLING) || (state_n == ST_SETTLING);
      show_q     <= (state_n == ST_SHOW);
      ivl_q      <= ivl_n;
      step_q     <= step_n;
      show_cnt_q <= show_cnt_n;
    end
  end

  assign bus.die_sel = die_q;
  assign bus.load    = load_q;
  assign bus.tick    = tick_q;
  assign bus.busy    = busy_q;
  assign bus.show    = show_q;

endmodule
